divider_restoring_signed: RTL and testbench

- Iterative signed/unsigned restoring divider.
- Acts as the responder on the team's start/done division handshake. The calculator controller drives `start`, `dividend` and `divisor`, then waits for `done` and takes the quotient into its running total.
- Adds a `busy` output, a divide-by-zero flag and two's-complement signed operation, so the calculator divides correctly on negative totals.

---
 rtl/types_pkg.sv | 24 ++
 rtl/divider_restoring_signed_div_step.sv | 25 ++
 rtl/divider_restoring_signed.sv | 144 ++++++++++++++
 tb/tb_divider_restoring_signed.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared word type, divider state encoding and the magnitude helper used by
// the signed divider.
package types_pkg;

    localparam int BITS = 32;

    typedef logic [BITS-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // One bit wider than the word so that |MIN| is representable.
    function automatic logic [BITS:0] abs_ext(input word_t v);
        logic [BITS:0] ext;
        ext = {v[BITS-1], v};
        return ext[BITS] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/divider_restoring_signed_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference if non-negative, otherwise restore.
import types_pkg::*;

module div_step #(
    parameter int WIDTH = BITS
) (
    input  logic [WIDTH:0] rem_i,
    input  logic           msb_i,
    input  logic [WIDTH:0] dvs_i,
    output logic [WIDTH:0] rem_o,
    output logic           q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The partial remainder stays below the divisor, so WIDTH+2 bits hold the
    // shifted value and the signed difference without overflow.
    assign shifted = {rem_i, msb_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign q_bit_o = ~trial[WIDTH+1];
    assign rem_o   = q_bit_o ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/divider_restoring_signed.sv
// Iterative restoring divider with start/done handshake, busy, divide-by-zero
// flag and optional two's-complement operation.
import types_pkg::*;

module divider_restoring_signed #(
    parameter int WIDTH  = BITS,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH:0]   dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_d;
    logic             q_bit_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH:0]   dvd_mag;
    logic [WIDTH:0]   dvs_mag;

    generate
        if (SIGNED && (WIDTH == BITS)) begin : g_pkg_abs
            assign dvd_mag = abs_ext(dvd_q);
            assign dvs_mag = abs_ext(dvs_q[WIDTH-1:0]);
        end else if (SIGNED) begin : g_local_abs
            logic [WIDTH:0] dvd_ext;
            logic [WIDTH:0] dvs_ext;
            assign dvd_ext = {dvd_q[WIDTH-1], dvd_q};
            assign dvs_ext = {dvs_q[WIDTH-1], dvs_q[WIDTH-1:0]};
            assign dvd_mag = dvd_ext[WIDTH] ? (~dvd_ext + 1'b1) : dvd_ext;
            assign dvs_mag = dvs_ext[WIDTH] ? (~dvs_ext + 1'b1) : dvs_ext;
        end else begin : g_unsigned
            assign dvd_mag = {1'b0, dvd_q};
            assign dvs_mag = {1'b0, dvs_q[WIDTH-1:0]};
        end
    endgenerate

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (rem_q),
        .msb_i   (dvd_q[WIDTH-1]),
        .dvs_i   (dvs_q),
        .rem_o   (rem_d),
        .q_bit_o (q_bit_d)
    );

    // Quotient bits shift into the vacated low end of the dividend register.
    assign dvd_d = {dvd_q[WIDTH-2:0], q_bit_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rmd_q   <= dividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= dividend;
                            dvs_q   <= {1'b0, divisor};
                            busy_q  <= 1'b1;
                            state_q <= PREP;
                        end
                    end
                end
                PREP: begin
                    q_neg_q <= SIGNED & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_q <= SIGNED & dvd_q[WIDTH-1];
                    dvd_q   <= WIDTH'(dvd_mag);
                    dvs_q   <= dvs_mag;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
                    rmd_q   <= WIDTH'(r_neg_q ? (~rem_q + 1'b1) : rem_q);
                    dz_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_divider_restoring_signed.sv
// Scoreboard bench: a signed and an unsigned divider instance, checked against
// plain integer division with a separate monitor per instance.
module tb_divider_restoring_signed;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_s = 1'b0;
    logic        start_u = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;

    logic        busy_s, done_s, dz_s, busy_u, done_u, dz_u;
    logic [31:0] q_s, r_s, q_u, r_u;

    always #5 clk = ~clk;

    divider_restoring_signed #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .dividend(dividend), .divisor(divisor),
        .busy(busy_s), .done(done_s), .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s)
    );

    divider_restoring_signed #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .dividend(dividend), .divisor(divisor),
        .busy(busy_u), .done(done_u), .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t qs[$];
    exp_t qu[$];

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        exp_t   e;
        longint sa, sb;
        e.a = a;
        e.b = b;
        e.cyc = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dz = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (done_s) begin
            if (qs.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done_s: got done at cycle %0d, required none", cyc);
            end else begin
                e = qs.pop_front();
                $display("[S] %h / %h -> q=%h r=%h dz=%b cyc=%0d", e.a, e.b, q_s, r_s, dz_s, cyc);
                chk("s_quotient", q_s, e.q);
                chk("s_remainder", r_s, e.r);
                chk("s_div_by_zero", {31'd0, dz_s}, {31'd0, e.dz});
                chk("s_latency", cyc, e.cyc);
                chk("s_busy_in_done", {31'd0, busy_s}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon_u
        exp_t e;
        if (done_u) begin
            if (qu.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done_u: got done at cycle %0d, required none", cyc);
            end else begin
                e = qu.pop_front();
                $display("[U] %h / %h -> q=%h r=%h dz=%b cyc=%0d", e.a, e.b, q_u, r_u, dz_u, cyc);
                chk("u_quotient", q_u, e.q);
                chk("u_remainder", r_u, e.r);
                chk("u_div_by_zero", {31'd0, dz_u}, {31'd0, e.dz});
                chk("u_latency", cyc, e.cyc);
            end
        end
    end

    // Drives one request; the accepting edge is the posedge right after it.
    task automatic issue(input bit u, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        if (u) start_u = 1'b1;
        else   start_s = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b, !u);
        e.cyc = cyc + ((b == 32'd0) ? 0 : 34);
        if (expect_done) begin
            if (u) qu.push_back(e);
            else   qs.push_back(e);
        end
        chk(u ? "u_busy_after_accept" : "s_busy_after_accept",
            {31'd0, (u ? busy_u : busy_s)}, {31'd0, (b != 32'd0)});
        start_s  = 1'b0;
        start_u  = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(input bit u);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(u ? done_u : done_s) && n < 100);
        if (n >= 100) begin
            checks++;
            $display("FAIL done_timeout: got no done within 100 cycles, required done");
        end
    endtask

    task automatic run(input bit u, input logic [31:0] a, input logic [31:0] b);
        issue(u, a, b, 1'b1);
        wait_done(u);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_s}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_s}, 32'd0);
        chk({tag, "_quotient"}, q_s, 32'd0);
        chk({tag, "_remainder"}, r_s, 32'd0);
        chk({tag, "_div_by_zero"}, {31'd0, dz_s}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_u_quotient", q_u, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7);
        run(1'b0, -32'sd100, 32'd7);
        run(1'b0, 32'd100, -32'sd7);
        run(1'b0, -32'sd100, -32'sd7);
        run(1'b0, 32'd55, 32'd0);
        run(1'b0, 32'd9, 32'd3);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b1, 32'hFFFF_FFFF, 32'd16);
        run(1'b1, 32'd55, 32'd0);

        // Requests during an operation must be ignored.
        issue(1'b0, 32'd1000, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        start_s = 1'b1; dividend = 32'd1; divisor = 32'd1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (14) @(negedge clk);
        start_s = 1'b1; dividend = 32'd1; divisor = 32'd1;
        @(negedge clk);
        start_s = 1'b0;
        chk("busy_mid_op", {31'd0, busy_s}, 32'd1);
        wait_done(1'b0);

        // Request presented during the DONE cycle must be ignored.
        start_s = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start_s = 1'b0;
        chk("busy_after_done_start", {31'd0, busy_s}, 32'd0);
        repeat (40) @(negedge clk);
        chk("idle_after_done_start", {31'd0, busy_s}, 32'd0);

        // Reset at edge 10 of an operation abandons it.
        issue(1'b0, 32'd1000, 32'd10, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(1'b0, 32'd8, 32'd2);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a, b;
            int          kind;
            kind = $urandom_range(0, 7);
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case (kind)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(1, 20));
                4: b = -32'($urandom_range(1, 20));
                5: b = {16'd0, 16'($urandom)};
                default: b = $urandom;
            endcase
            if (kind == 5) a = {24'd0, 8'($urandom)};
            run(1'b0, a, b);
        end

        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            run(1'b1, a, b);
        end

        repeat (5) @(negedge clk);
        chk("s_queue_empty", qs.size(), 32'd0);
        chk("u_queue_empty", qu.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
